// File: rtl/pipelined_reduce_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_reduce_gate_pkg
// Description : Shared definitions for the pipelined reduction gate.
//               - op_e        : reduction operation encoding (6/7 illegal)
//               - clog_radix  : ceil(log_RADIX(n)), floored at 1 (stage count)
//               - stage_width : operand width entering tree level k
//               - stage_offset: bit offset of level j in the flattened bus
//               - identity_bit: padding value for unused leaves
//               - node_reduce : single tree-node reduction (up to 8 inputs)
//               - is_illegal  : flags in_op values outside the legal set
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_reduce_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    localparam int C_OP_W      = 3;
    localparam int C_MAX_RADIX = 8;

    // Smallest s >= 1 with r**s >= n.
    function automatic int clog_radix(input int n, input int r);
        int s;
        int p;
        s = 0;
        p = 1;
        while (p < n) begin
            p = p * r;
            s = s + 1;
        end
        if (s < 1) begin
            s = 1;
        end
        return s;
    endfunction

    // Width after k tree levels: repeated ceil division by the radix.
    function automatic int stage_width(input int n, input int r, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) begin
            w = (w + r - 1) / r;
        end
        return w;
    endfunction

    // All levels (input level 0 through the final 1-bit level) are packed
    // side by side in one vector; this gives the LSB position of level j.
    function automatic int stage_offset(input int n, input int r, input int j);
        int off;
        off = 0;
        for (int i = 0; i < j; i++) begin
            off = off + stage_width(n, r, i);
        end
        return off;
    endfunction

    function automatic logic is_illegal(input logic [C_OP_W-1:0] op);
        return (op > 3'd5);
    endfunction

    // AND-family pads with 1; OR and XOR families pad with 0.
    function automatic logic identity_bit(input logic [C_OP_W-1:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    // Inversion is deliberately not applied here; only the base op.
    function automatic logic node_reduce(input logic [C_MAX_RADIX-1:0] bits,
                                         input logic [C_OP_W-1:0]      op);
        logic res;
        case (op)
            OP_AND, OP_NAND: res = &bits;
            OP_OR,  OP_NOR:  res = |bits;
            default:         res = ^bits;
        endcase
        return res;
    endfunction

endpackage : pipelined_reduce_gate_pkg
`default_nettype wire

// File: rtl/pipelined_reduce_gate_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_reduce_gate_if
// Description : Valid/ready handshake bundle for the pipelined reduction gate.
//   in_data  [N_IN] producer -> gate   operand bits
//   in_op    [3]    producer -> gate   operation code
//   in_valid        producer -> gate   in_data/in_op qualified
//   in_ready        gate -> producer   beat accepted this cycle
//   out_data        gate -> consumer   reduction result
//   out_err         gate -> consumer   result from an illegal op
//   out_valid       gate -> consumer   out_data/out_err qualified
//   out_ready       consumer -> gate   result accepted this cycle
//   Modports: master (environment side), slave (gate side).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_reduce_gate_if #(
    parameter int N_IN = 5
) ();
    logic [N_IN-1:0] in_data;
    logic [2:0]      in_op;
    logic            in_valid;
    logic            in_ready;
    logic            out_data;
    logic            out_err;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_op, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, in_op, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface : pipelined_reduce_gate_if
`default_nettype wire

// File: rtl/pipelined_reduce_gate_reduce_stage.sv
`default_nettype none
// ============================================================================
// Module      : reduce_stage
// Description : One registered level of the reduction tree. Groups the
//               W_IN input bits into W_OUT nodes of RADIX leaves each,
//               pads the tail with the op identity, reduces each node with
//               the base op and registers the result alongside valid/op/err.
//               The FINAL instance also applies NAND/NOR/XNOR inversion and
//               forces the result to 0 for illegal ops.
//   clk, rst_n          clock, synchronous active-low reset
//   i_en                pipeline advance (hold when 0)
//   i_valid/i_op/i_err  sideband from the previous level
//   i_data  [W_IN]      bits from the previous level
//   o_valid/o_op/o_err  registered sideband
//   o_data  [W_OUT]     registered node results
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_stage
    import pipelined_reduce_gate_pkg::*;
#(
    parameter int W_IN  = 5,
    parameter int W_OUT = 3,
    parameter int RADIX = 2,
    parameter bit FINAL = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_en,
    input  wire logic              i_valid,
    input  wire logic [C_OP_W-1:0] i_op,
    input  wire logic              i_err,
    input  wire logic [W_IN-1:0]   i_data,
    output logic                   o_valid,
    output logic [C_OP_W-1:0]      o_op,
    output logic                   o_err,
    output logic [W_OUT-1:0]       o_data
);

    localparam int C_W_PAD = W_OUT * RADIX;

    logic [C_W_PAD-1:0]     w_leaves;
    logic [C_MAX_RADIX-1:0] w_bits;
    logic [W_OUT-1:0]       w_node;
    logic [W_OUT-1:0]       w_next;

    logic                   r_valid;
    logic [C_OP_W-1:0]      r_op;
    logic                   r_err;
    logic [W_OUT-1:0]       r_data;

    always_comb begin
        w_leaves             = {C_W_PAD{identity_bit(i_op)}};
        w_leaves[W_IN-1:0]   = i_data;
        w_bits               = '0;
        w_node               = '0;
        for (int g = 0; g < W_OUT; g++) begin
            // Unused node inputs beyond RADIX also take the identity value.
            w_bits              = {C_MAX_RADIX{identity_bit(i_op)}};
            w_bits[RADIX-1:0]   = w_leaves[g*RADIX +: RADIX];
            w_node[g]           = node_reduce(w_bits, i_op);
        end
    end

    generate
        if (FINAL) begin : g_final
            // Legal inverting ops (1,3,5) all have bit 0 set.
            always_comb begin
                w_next = w_node;
                if (i_err) begin
                    w_next = '0;
                end else if (i_op[0]) begin
                    w_next = ~w_node;
                end
            end
        end else begin : g_inner
            always_comb begin
                w_next = w_node;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_op    <= i_op;
            r_err   <= i_err;
            r_data  <= w_next;
        end
    end

    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_err   = r_err;
    assign o_data  = r_data;

endmodule : reduce_stage
`default_nettype wire

// File: rtl/pipelined_reduce_gate.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_reduce_gate
// Description : Pipelined RADIX-ary reduction (AND/NAND/OR/NOR/XOR/XNOR) of
//               N_IN bits with valid/ready flow control. One register stage
//               per tree level, STAGES = max(1, ceil(log_RADIX(N_IN))).
//               All stages advance together when the output slot is empty
//               or being consumed; otherwise the whole pipe holds.
//   clk     sole clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     pipelined_reduce_gate_if.slave (in_* / out_* handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_reduce_gate
    import pipelined_reduce_gate_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int RADIX = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    pipelined_reduce_gate_if.slave bus
);

    localparam int STAGES    = clog_radix(N_IN, RADIX);
    localparam int C_TOTAL_W = stage_offset(N_IN, RADIX, STAGES + 1);

    // Level 0 is the raw input, level k+1 is the register output of stage k.
    logic [C_TOTAL_W-1:0]            w_data;
    logic [STAGES:0]                 w_valid;
    logic [STAGES:0]                 w_err;
    logic [STAGES:0][C_OP_W-1:0]     w_op;
    logic                            w_adv;

    assign w_adv        = !w_valid[STAGES] || bus.out_ready;
    assign bus.in_ready = w_adv && rst_n;

    assign w_data[N_IN-1:0] = bus.in_data;
    assign w_valid[0]       = bus.in_valid;
    assign w_op[0]          = bus.in_op;
    assign w_err[0]         = is_illegal(bus.in_op);

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int C_W_I   = stage_width(N_IN, RADIX, k);
            localparam int C_W_O   = stage_width(N_IN, RADIX, k + 1);
            localparam int C_OFF_I = stage_offset(N_IN, RADIX, k);
            localparam int C_OFF_O = stage_offset(N_IN, RADIX, k + 1);

            reduce_stage #(
                .W_IN  (C_W_I),
                .W_OUT (C_W_O),
                .RADIX (RADIX),
                .FINAL (k == STAGES - 1)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_adv),
                .i_valid (w_valid[k]),
                .i_op    (w_op[k]),
                .i_err   (w_err[k]),
                .i_data  (w_data[C_OFF_I +: C_W_I]),
                .o_valid (w_valid[k+1]),
                .o_op    (w_op[k+1]),
                .o_err   (w_err[k+1]),
                .o_data  (w_data[C_OFF_O +: C_W_O])
            );
        end
    endgenerate

    // The final level is one bit wide and sits at the top of the bus.
    assign bus.out_data  = w_data[C_TOTAL_W-1];
    assign bus.out_err   = w_err[STAGES];
    assign bus.out_valid = w_valid[STAGES];

endmodule : pipelined_reduce_gate
`default_nettype wire

// File: tb/tb_pipelined_reduce_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_reduce_gate
// Description : Directed self-checking bench for pipelined_reduce_gate
//               (N_IN=5, RADIX=2, STAGES=3). Inputs change #1 after the
//               rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_reduce_gate;
    import pipelined_reduce_gate_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipelined_reduce_gate_if #(.N_IN(5)) bus ();

    pipelined_reduce_gate #(
        .N_IN  (5),
        .RADIX (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] d, input logic [2:0] op);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_op    = op;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic d, input logic e);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        check({tag, "_data"},  {31'd0, bus.out_data},  {31'd0, d});
        check({tag, "_err"},   {31'd0, bus.out_err},   {31'd0, e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         got;
        logic [3:0] got_vals;
        logic       seen;

        checks        = 0;
        failures      = 0;
        got_vals      = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'b11111;
        bus.in_op     = OP_AND;
        bus.out_ready = 1'b1;

        // Reset held 2 cycles with a valid beat offered
        tick();
        tick();
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Back-to-back beats: expected 0, 1, 1, 1
        send(5'b11111, OP_NAND);
        check("lat_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        send(5'b11111, OP_AND);
        check("lat_e2_valid", {31'd0, bus.out_valid}, 32'd0);
        send(5'b10000, OP_OR);
        chk_out("b2b_nand", 1'b1, 1'b0, 1'b0);
        send(5'b10110, OP_XOR);
        chk_out("b2b_and", 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk_out("b2b_or", 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("b2b_xor", 1'b1, 1'b1, 1'b0);
        tick();
        check("b2b_bubble_valid", {31'd0, bus.out_valid}, 32'd0);

        // Padding: AND of all ones stays 1; NOR of all zeros is 1
        send(5'b11111, OP_AND);
        send(5'b00000, OP_NOR);
        bus.in_valid = 1'b0;
        tick();
        chk_out("pad_and", 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("pad_nor", 1'b1, 1'b1, 1'b0);

        // Illegal op then a legal XNOR (00011 -> xor 0 -> xnor 1)
        send(5'b11111, 3'd7);
        send(5'b00011, OP_XNOR);
        bus.in_valid = 1'b0;
        tick();
        chk_out("illegal", 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("legal_after", 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: results 0 (AND), 1 (OR), 0 (XOR)
        send(5'b10000, OP_AND);
        send(5'b01000, OP_OR);
        send(5'b00110, OP_XOR);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_data",  {31'd0, bus.out_data},  32'd0);
            check("bp_hold_ready", {31'd0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid && bus.out_ready) begin
                if (got < 4) begin
                    got_vals[got] = bus.out_data;
                end
                got++;
            end
            tick();
        end
        check("bp_count", got, 32'd3);
        check("bp_res0", {31'd0, got_vals[0]}, 32'd0);
        check("bp_res1", {31'd0, got_vals[1]}, 32'd1);
        check("bp_res2", {31'd0, got_vals[2]}, 32'd0);

        // Mid-flight reset discards two accepted beats
        send(5'b11111, OP_AND);
        send(5'b11111, OP_OR);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) begin
                seen = 1'b1;
            end
        end
        check("mid_rst_no_output", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipelined_reduce_gate
`default_nettype wire
